// File: rtl/modulus_hex_sched_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// modulus_hex_sched_if : start / ROM-bank / result bundle of modulus_hex_sched
// Revision: 1.0
// ----------------------------------------------------------------------------
interface modulus_hex_sched_if #(
  parameter int MODULUS_WIDTH = 1024,
  parameter int NUM_DIGITS    = 6,
  parameter int ACC_EXTRA     = 3
);
  localparam int c_SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                                 start_valid;
  logic                                 start_ready;
  logic [6*NUM_DIGITS-1:0]              ovf_in;
  logic [MODULUS_WIDTH-1:0]             base_in;
  logic                                 rom_en;
  logic [c_SEL_W-1:0]                   rom_sel;
  logic [5:0]                           rom_digit;
  logic [MODULUS_WIDTH-1:0]             rom_data;
  logic                                 res_valid;
  logic                                 res_ready;
  logic [MODULUS_WIDTH+ACC_EXTRA-1:0]   res_out;
  logic                                 busy;

  modport master (
    output start_valid, ovf_in, base_in, rom_data, res_ready,
    input  start_ready, rom_en, rom_sel, rom_digit, res_valid, res_out, busy
  );

  modport slave (
    input  start_valid, ovf_in, base_in, rom_data, res_ready,
    output start_ready, rom_en, rom_sel, rom_digit, res_valid, res_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/modulus_hex_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// modulus_hex_sched : time-shares one modulus_hex ROM bank across overflow digits
// Revision: 1.0
// ----------------------------------------------------------------------------
module modulus_hex_sched #(
  parameter int MODULUS_WIDTH = 1024,
  parameter int NUM_DIGITS    = 6,
  parameter int ROM_LATENCY   = 1,
  parameter int ACC_EXTRA     = 3
) (
  input  wire logic         clk,
  input  wire logic         reset,
  modulus_hex_sched_if.slave bus
);
  localparam int c_SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_ACC_W = MODULUS_WIDTH + ACC_EXTRA;
  localparam int c_OVF_W = 6 * NUM_DIGITS;
  localparam logic [c_SEL_W-1:0] c_LAST_SEL = c_SEL_W'(NUM_DIGITS - 1);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_ISSUE = 2'd1;
  localparam logic [1:0] c_S_DRAIN = 2'd2;
  localparam logic [1:0] c_S_DONE  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [c_OVF_W-1:0]  r_digits;
  logic                r_rom_en;
  logic [c_SEL_W-1:0]  r_rom_sel;
  logic [5:0]          r_rom_digit;
  logic [c_ACC_W-1:0]  r_acc;
  logic                w_accept;
  logic                w_last_issue;
  logic                w_ret_valid;
  logic                w_drain_done;
  logic                w_start_ready;
  logic                w_busy;
  logic                w_res_valid;

  assign w_accept     = (r_state == c_S_IDLE) && bus.start_valid;
  assign w_last_issue = (r_state == c_S_ISSUE) && (r_rom_sel == c_LAST_SEL);

  // Return-valid tracking: the ROM answers ROM_LATENCY cycles after each strobe.
  generate
    if (ROM_LATENCY == 0) begin : g_lat_zero
      assign w_ret_valid  = r_rom_en;
      assign w_drain_done = 1'b1;
    end else begin : g_lat_pipe
      localparam logic [ROM_LATENCY-1:0] c_TAIL_ONLY = ROM_LATENCY'(1) << (ROM_LATENCY - 1);
      logic [ROM_LATENCY-1:0] r_vpipe;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_vpipe <= '0;
        end else begin
          r_vpipe <= ROM_LATENCY'({r_vpipe, r_rom_en});
        end
      end

      assign w_ret_valid  = r_vpipe[ROM_LATENCY-1];
      // Strobes have stopped in DRAIN; done once only the oldest return remains.
      assign w_drain_done = (r_vpipe == c_TAIL_ONLY);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (bus.start_valid) begin
          w_next_state = c_S_ISSUE;
        end
      end
      c_S_ISSUE: begin
        if (r_rom_sel == c_LAST_SEL) begin
          w_next_state = (ROM_LATENCY > 0) ? c_S_DRAIN : c_S_DONE;
        end
      end
      c_S_DRAIN: begin
        if (w_drain_done) begin
          w_next_state = c_S_DONE;
        end
      end
      c_S_DONE: begin
        if (bus.res_ready) begin
          w_next_state = c_S_IDLE;
        end
      end
      default: w_next_state = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_start_ready = 1'b0;
    w_busy        = 1'b1;
    w_res_valid   = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        w_start_ready = 1'b1;
        w_busy        = 1'b0;
      end
      c_S_DONE: begin
        w_res_valid = 1'b1;
      end
      default: begin
        w_start_ready = 1'b0;
      end
    endcase
  end

  // Issue side: the strobe for digit 0 is set up at accept so it is visible
  // in the first cycle after accept; later digits come out of the shifter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digits    <= '0;
      r_rom_en    <= 1'b0;
      r_rom_sel   <= '0;
      r_rom_digit <= '0;
    end else if (w_accept) begin
      r_digits    <= bus.ovf_in >> 6;
      r_rom_en    <= 1'b1;
      r_rom_sel   <= '0;
      r_rom_digit <= bus.ovf_in[5:0];
    end else if (w_last_issue) begin
      r_rom_en    <= 1'b0;
      r_rom_sel   <= '0;
      r_rom_digit <= '0;
    end else if (r_state == c_S_ISSUE) begin
      r_digits    <= r_digits >> 6;
      r_rom_sel   <= r_rom_sel + c_SEL_W'(1);
      r_rom_digit <= r_digits[5:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= {{ACC_EXTRA{1'b0}}, bus.base_in};
    end else if (w_ret_valid) begin
      r_acc <= r_acc + {{ACC_EXTRA{1'b0}}, bus.rom_data};
    end
  end

  assign bus.start_ready = w_start_ready;
  assign bus.busy        = w_busy;
  assign bus.res_valid   = w_res_valid;
  assign bus.res_out     = r_acc;
  assign bus.rom_en      = r_rom_en;
  assign bus.rom_sel     = r_rom_sel;
  assign bus.rom_digit   = r_rom_digit;
endmodule
`default_nettype wire

// File: tb/tb_modulus_hex_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_modulus_hex_sched : three scheduler lanes (ROM latency 1, 0, 3) on mock ROMs
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_modulus_hex_sched;
  logic clk = 1'b0;
  logic reset;
  logic ones_mode;

  logic [2:0]  sv_a;
  logic [2:0]  rr_a;
  logic [15:0] base_a [3];
  logic [35:0] ovf_a  [3];

  wire [2:0]  sr_w;
  wire [2:0]  busy_w;
  wire [2:0]  en_w;
  wire [2:0]  rv_w;
  wire [2:0]  sel_w [3];
  wire [5:0]  dig_w [3];
  wire [18:0] ro_w  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_lane
    localparam int c_LAT = (k == 0) ? 1 : ((k == 1) ? 0 : 3);

    modulus_hex_sched_if #(.MODULUS_WIDTH(16), .NUM_DIGITS(6), .ACC_EXTRA(3)) bus ();

    modulus_hex_sched #(
      .MODULUS_WIDTH(16), .NUM_DIGITS(6), .ROM_LATENCY(c_LAT), .ACC_EXTRA(3)
    ) dut (
      .clk(clk), .reset(reset), .bus(bus)
    );

    assign bus.start_valid = sv_a[k];
    assign bus.res_ready   = rr_a[k];
    assign bus.base_in     = base_a[k];
    assign bus.ovf_in      = ovf_a[k];
    assign sr_w[k]   = bus.start_ready;
    assign busy_w[k] = bus.busy;
    assign en_w[k]   = bus.rom_en;
    assign rv_w[k]   = bus.res_valid;
    assign sel_w[k]  = bus.rom_sel;
    assign dig_w[k]  = bus.rom_digit;
    assign ro_w[k]   = bus.res_out;

    // Mock ROM: digit*(sel+1), garbage whenever no lookup was issued.
    wire [15:0] w_f = ones_mode ? 16'hFFFF
                                : 16'(bus.rom_digit) * (16'(bus.rom_sel) + 16'd1);
    if (c_LAT == 0) begin : g_comb
      assign bus.rom_data = bus.rom_en ? w_f : 16'hBEEF;
    end else begin : g_pipe
      logic [15:0] r_pd [c_LAT];
      always_ff @(posedge clk) begin
        r_pd[0] <= bus.rom_en ? w_f : 16'hBEEF;
        for (int i = 1; i < c_LAT; i++) r_pd[i] <= r_pd[i-1];
      end
      assign bus.rom_data = r_pd[c_LAT-1];
    end
  end

  typedef struct {
    logic [15:0] base;
    logic [35:0] ovf;
    logic        ones;
    logic [18:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rst_view(input int k);
    return {sr_w[k], busy_w[k], en_w[k], sel_w[k], dig_w[k], rv_w[k], ro_w[k]};
  endfunction

  task automatic launch(input int k, input logic [15:0] base, input logic [35:0] ovf);
    @(negedge clk);
    for (int i = 0; i < 20 && !sr_w[k]; i++) @(negedge clk);
    sv_a[k]   = 1'b1;
    base_a[k] = base;
    ovf_a[k]  = ovf;
    @(posedge clk);
    #1;
    sv_a[k] = 1'b0;
  endtask

  // Called just after the accept edge; rel counts cycles from accept.
  task automatic collect(input int k, input logic [35:0] ovf,
                         output logic [18:0] res, output int lat, output int bad);
    logic       e;
    logic [2:0] s;
    logic [5:0] d;
    lat = -1;
    res = '0;
    bad = 0;
    for (int rel = 1; rel <= 40; rel++) begin
      @(negedge clk);
      if (rel <= 7) begin
        e = (rel <= 6);
        s = 3'd0;
        d = 6'd0;
        if (e) begin
          s = 3'(rel - 1);
          d = ovf[6*(rel-1) +: 6];
        end
        if (en_w[k] !== e || sel_w[k] !== s || dig_w[k] !== d) bad++;
      end
      if (rv_w[k]) begin
        lat = rel;
        res = ro_w[k];
        break;
      end
    end
  endtask

  vec_t        vecs [6];
  logic [35:0] c_v0;
  logic [35:0] c_v_ones;
  logic [35:0] c_v_fives;
  logic [18:0] res;
  logic [18:0] held;
  int          lat;
  int          bad;

  initial begin
    c_v0      = {6'd0, 6'd0, 6'd0, 6'd3, 6'd2, 6'd1};
    c_v_ones  = {6{6'd1}};
    c_v_fives = {6{6'd5}};
    vecs[0] = '{16'h0010, c_v0,                                        1'b0, 19'h0001E};
    vecs[1] = '{16'hFFFF, {6{6'd63}},                                  1'b1, 19'h6FFF9};
    vecs[2] = '{16'h0000, {6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 6'd63},       1'b0, 19'h00045};
    vecs[3] = '{16'h1234, c_v_fives,                                   1'b0, 19'h0129D};
    vecs[4] = '{16'hABCD, 36'd0,                                       1'b0, 19'h0ABCD};
    vecs[5] = '{16'h0000, {6{6'd63}},                                  1'b0, 19'h0052B};

    reset     = 1'b1;
    ones_mode = 1'b0;
    sv_a      = 3'b000;
    rr_a      = 3'b111;
    for (int k = 0; k < 3; k++) begin
      base_a[k] = '0;
      ovf_a[k]  = '0;
    end
    repeat (2) @(negedge clk);
    check("reset_lane1", 64'(rst_view(0)), 64'h8000_0000);
    check("reset_lane3", 64'(rst_view(2)), 64'h8000_0000);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      ones_mode = vecs[v].ones;
      launch(0, vecs[v].base, vecs[v].ovf);
      collect(0, vecs[v].ovf, res, lat, bad);
      check($sformatf("vec%0d_res", v), 64'(res), 64'(vecs[v].exp));
      check($sformatf("vec%0d_lat", v), 64'(lat), 64'd8);
      check($sformatf("vec%0d_issue", v), 64'(bad), 64'd0);
    end
    ones_mode = 1'b0;

    launch(1, 16'h0010, c_v0);
    collect(1, c_v0, res, lat, bad);
    check("lat0_res", 64'(res), 64'h1E);
    check("lat0_lat", 64'(lat), 64'd7);
    check("lat0_issue", 64'(bad), 64'd0);
    launch(2, 16'h0010, c_v0);
    collect(2, c_v0, res, lat, bad);
    check("lat3_res", 64'(res), 64'h1E);
    check("lat3_lat", 64'(lat), 64'd10);
    check("lat3_issue", 64'(bad), 64'd0);

    // Backpressure: five cycles of res_ready=0 with a competing start request.
    @(negedge clk);
    rr_a[0] = 1'b0;
    launch(0, 16'h0010, c_v0);
    collect(0, c_v0, held, lat, bad);
    check("bp_res", 64'(held), 64'h1E);
    bad = 0;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      if (rv_w[0] !== 1'b1 || ro_w[0] !== held || sr_w[0] !== 1'b0) bad++;
      if (j == 0) begin
        sv_a[0]   = 1'b1;
        base_a[0] = 16'h0100;
        ovf_a[0]  = c_v_ones;
      end
      if (j == 4) rr_a[0] = 1'b1;
    end
    check("bp_stable", 64'(bad), 64'd0);
    @(negedge clk);
    check("bp_ready_after", 64'({sr_w[0], busy_w[0]}), 64'b10);
    @(posedge clk);
    #1;
    sv_a[0] = 1'b0;
    collect(0, c_v_ones, res, lat, bad);
    check("bp_next_res", 64'(res), 64'h115);
    check("bp_next_lat", 64'(lat), 64'd8);

    // Back-to-back with start_valid held high.
    begin
      int          v1, a2, v2;
      logic [18:0] r1, r2;
      v1 = -1; a2 = -1; v2 = -1; r1 = '0; r2 = '0;
      @(negedge clk);
      sv_a[0]   = 1'b1;
      base_a[0] = 16'h0010;
      ovf_a[0]  = c_v0;
      @(posedge clk);
      #1;
      base_a[0] = 16'h1234;
      ovf_a[0]  = c_v_fives;
      for (int rel = 1; rel <= 25; rel++) begin
        @(negedge clk);
        if (rv_w[0] && v1 < 0) begin
          v1 = rel;
          r1 = ro_w[0];
        end else if (rv_w[0] && a2 >= 0 && v2 < 0) begin
          v2 = rel;
          r2 = ro_w[0];
        end
        if (sr_w[0] && sv_a[0] && a2 < 0) a2 = rel;
        if (a2 >= 0 && rel == a2 + 1) sv_a[0] = 1'b0;
      end
      sv_a[0] = 1'b0;
      check("b2b_v1", 64'(v1), 64'd8);
      check("b2b_r1", 64'(r1), 64'h1E);
      check("b2b_accept2", 64'(a2), 64'd9);
      check("b2b_v2", 64'(v2), 64'd17);
      check("b2b_r2", 64'(r2), 64'h129D);
    end

    // Asynchronous reset at cycle 4 of an operation.
    launch(0, 16'h0010, c_v0);
    repeat (4) @(negedge clk);
    check("rst_pre_busy", 64'(busy_w[0]), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_mid", 64'(rst_view(0)), 64'h8000_0000);
    @(negedge clk);
    reset = 1'b0;
    launch(0, 16'h0020, c_v0);
    collect(0, c_v0, res, lat, bad);
    check("rst_after_res", 64'(res), 64'h2E);
    check("rst_after_lat", 64'(lat), 64'd8);
    check("rst_after_issue", 64'(bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
